// File: rtl/hft_pkg.sv
// Shared constants and types for the ITCH add-order message path.
package hft_pkg;

   localparam int REG_WIDTH     = 32;
   localparam int WORDS_PER_MSG = 9;

   localparam logic [7:0] ITCH_ADD_MSG_TYPE = 8'h41;

   typedef enum logic {
      BUY  = 1'b0,
      SELL = 1'b1
   } side_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_BUY  = 2'd1,
      SEND_SELL = 2'd2
   } ser_state_t;

endpackage

// File: rtl/msg_pair_fifo.sv
// Synchronous FIFO of buy/sell message pairs; head is read combinationally at the read pointer.
module msg_pair_fifo #(
   parameter int W     = 576,
   parameter int DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       wr_en,
   input  logic [W-1:0]               wr_data,
   input  logic                       rd_en,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the address bits match.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (wr_en && !full) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/order_msg_serializer.sv
// Buffers buy/sell message pairs and streams them as buy words 0..8 then sell words 0..8.
// Handshake: a beat transfers on a rising edge where o_tvalid & i_tready; outputs hold while stalled.
module order_msg_serializer
   import hft_pkg::*;
#(
   parameter int REG_WIDTH     = hft_pkg::REG_WIDTH,
   parameter int WORDS_PER_MSG = hft_pkg::WORDS_PER_MSG,
   parameter int DEPTH         = 2,
   parameter int DROP_CNT_W    = 16
) (
   input  logic                              i_clk,
   input  logic                              i_reset_n,
   input  logic                              i_valid,
   input  logic [WORDS_PER_MSG*REG_WIDTH-1:0] i_msg_b,
   input  logic [WORDS_PER_MSG*REG_WIDTH-1:0] i_msg_s,
   output logic [REG_WIDTH-1:0]              o_tdata,
   output logic                              o_tvalid,
   input  logic                              i_tready,
   output logic                              o_tlast,
   output logic                              o_tside,
   output logic                              o_full,
   output logic [DROP_CNT_W-1:0]             o_drop_count
);

   localparam int MSG_W = WORDS_PER_MSG * REG_WIDTH;
   localparam int IDX_W = $clog2(WORDS_PER_MSG);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_MSG - 1);

   logic [2*MSG_W-1:0]   head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   logic                 wr_en;
   logic                 rd_en;

   ser_state_t           state;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     next_idx;
   side_t                side;
   logic                 handshake;
   logic [MSG_W-1:0]     cur_msg;
   logic [REG_WIDTH-1:0] words [WORDS_PER_MSG];

   assign handshake = o_tvalid & i_tready;
   assign next_idx  = idx + 1'b1;
   assign wr_en     = i_valid & ~fifo_full;
   assign rd_en     = handshake && (state == SEND_SELL) && (idx == LAST_IDX);
   assign o_full    = fifo_full;
   assign o_tside   = side;

   msg_pair_fifo #(
      .W     (2 * MSG_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .wr_en     (wr_en),
      .wr_data   ({i_msg_s, i_msg_b}),
      .rd_en     (rd_en),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Data is a mux of registered state, index and the head slot, which only changes on pop.
   always_comb begin
      cur_msg = (state == SEND_SELL) ? head[2*MSG_W-1:MSG_W] : head[MSG_W-1:0];
      for (int k = 0; k < WORDS_PER_MSG; k++) begin
         words[k] = cur_msg[k*REG_WIDTH +: REG_WIDTH];
      end
      o_tdata = (state == IDLE) ? '0 : words[idx];
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state    <= IDLE;
         idx      <= '0;
         side     <= BUY;
         o_tvalid <= 1'b0;
         o_tlast  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state    <= SEND_BUY;
                  idx      <= '0;
                  side     <= BUY;
                  o_tvalid <= 1'b1;
                  o_tlast  <= 1'b0;
               end
            end
            SEND_BUY: begin
               if (handshake) begin
                  if (idx == LAST_IDX) begin
                     state   <= SEND_SELL;
                     idx     <= '0;
                     side    <= SELL;
                     o_tlast <= 1'b0;
                  end else begin
                     idx     <= next_idx;
                     o_tlast <= (next_idx == LAST_IDX);
                  end
               end
            end
            SEND_SELL: begin
               if (handshake) begin
                  if (idx == LAST_IDX) begin
                     idx     <= '0;
                     o_tlast <= 1'b0;
                     side    <= BUY;
                     // Another pair behind the head: start it on the next beat with no bubble.
                     if (fifo_count > CNT_W'(1)) begin
                        state <= SEND_BUY;
                     end else begin
                        state    <= IDLE;
                        o_tvalid <= 1'b0;
                     end
                  end else begin
                     idx     <= next_idx;
                     o_tlast <= (next_idx == LAST_IDX);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               idx      <= '0;
               side     <= BUY;
               o_tvalid <= 1'b0;
               o_tlast  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_drop_count <= '0;
      end else if (i_valid && fifo_full && (o_drop_count != '1)) begin
         o_drop_count <= o_drop_count + 1'b1;
      end
   end

endmodule

// File: doc/order_msg_serializer.md
Name: order_msg_serializer

Overview:
Downstream neighbour of the ITCH add-order message builder. Each build cycle delivers a buy/sell message pair: two 9-word (36-byte) messages, each word REG_WIDTH bits. This block buffers whole pairs in a small FIFO and streams them as one 32-bit AXI-Stream-style word stream toward the network TX path. The buy message goes first, then the sell message, each terminated by o_tlast.

Parameters:
REG_WIDTH, 32, width of one message word.
WORDS_PER_MSG, 9, words per message (fixed by the ITCH add-order layout).
DEPTH, 2, pair slots in the buffer; power of 2, at least 2.
DROP_CNT_W, 16, width of the drop counter.

Ports:
i_clk  in  1  clock, rising edge.
i_reset_n  in  1  synchronous reset, active-low.
i_valid  in  1  one-cycle strobe; i_msg_b and i_msg_s hold a complete pair.
i_msg_b  in  WORDS_PER_MSG*REG_WIDTH  buy message; word k at [k*REG_WIDTH +: REG_WIDTH].
i_msg_s  in  WORDS_PER_MSG*REG_WIDTH  sell message; same packing as i_msg_b.
o_tdata  out  REG_WIDTH  current stream word.
o_tvalid  out  1  o_tdata is valid.
i_tready  in  1  sink accepts the word this cycle.
o_tlast  out  1  high on word 8 of each message.
o_tside  out  1  0 while a buy word is presented, 1 while a sell word is presented.
o_full  out  1  buffer full; a pair strobed now is dropped.
o_drop_count  out  DROP_CNT_W  pairs dropped since reset; saturates.

Behaviour:
- Reset (i_reset_n=0 at a rising edge):
  - FIFO empty, FSM to IDLE, word index 0.
  - o_tvalid=0, o_tlast=0, o_tside=0, o_tdata=0, o_full=0, o_drop_count=0.
  - Reset mid-packet abandons the packet: no further beats and no o_tlast for it.
- Write path:
  - When i_valid=1 and o_full=0, the pair is written at that edge.
  - When i_valid=1 and o_full=1, the pair is dropped and o_drop_count increments, saturating at all-ones.
  - o_full is a registered value. A pop in the same cycle does not free a slot for that write, so write-while-full drops even when a pop occurs.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare.
  - Simultaneous write and pop (not full): count unchanged, both performed.
- FSM states: IDLE, SEND_BUY, SEND_SELL.
  - IDLE -> SEND_BUY when the FIFO is non-empty; index=0.
  - SEND_BUY, handshake (o_tvalid & i_tready) with index<8: index+1.
  - SEND_BUY, handshake at index 8 -> SEND_SELL, index=0.
  - SEND_SELL, handshake with index<8: index+1.
  - SEND_SELL, handshake at index 8: pop the head. If count>1 before the pop, go to SEND_BUY with index 0 (no bubble between pairs); otherwise go to IDLE.
- Output rules:
  - o_tvalid=1 in SEND_BUY and SEND_SELL, 0 in IDLE.
  - o_tdata = head-entry word[index] of the buy (SEND_BUY) or sell (SEND_SELL) message; 0 in IDLE.
  - o_tlast = o_tvalid & (index==8).
  - o_tside = 1 in SEND_SELL.
  - o_tdata, o_tlast and o_tside stay stable while o_tvalid=1 and i_tready=0; the head entry does not change until it is popped.
- Latency: i_valid at edge N with an empty FIFO gives o_tvalid=1 with word 0 of buy in the cycle after edge N+1 (2 cycles).
- Throughput: 18 beats per pair with continuous i_tready. The upstream rate of 1 pair per cycle is absorbed only up to DEPTH; the excess is dropped and counted.
- i_tready may toggle freely. No combinational path from i_tready to o_tvalid.

Decomposition:
- Package hft_pkg holds:
  - REG_WIDTH and WORDS_PER_MSG localparams.
  - side_t enum {BUY=0, SELL=1}.
  - ser_state_t enum {IDLE, SEND_BUY, SEND_SELL}.
  - ITCH_ADD_MSG_TYPE = 8'h41.
- Sub-module msg_pair_fifo: synchronous FIFO of width 2*WORDS_PER_MSG*REG_WIDTH, depth DEPTH, active-low sync reset, exposes head, full, empty, count.
- Top level is the FSM, word mux and drop counter.

Test Plan:
- Single pair, i_tready=1. Buy word k = 0xB000_000k, sell word k = 0x5000_000k; i_valid at edge 0 -> beats start 2 cycles later, 18 consecutive beats in order. o_tlast on beats 9 and 18; o_tside=0 for beats 1-9 and 1 for 10-18. Then IDLE with o_tvalid=0.
- Backpressure: same pair, i_tready pseudo-random at 50% -> identical word sequence. Data/last/side held constant across every stall cycle; no beat lost or duplicated.
- Overflow, DEPTH=2, i_tready=0: 3 pairs on consecutive cycles -> o_full=1 after the second write, o_drop_count=1. Then set i_tready=1 -> exactly pairs 1 and 2 emitted (36 beats).
- Back-to-back: 2 pairs queued, i_tready=1 -> 36 contiguous beats, no o_tvalid gap between sell word 8 of pair 1 and buy word 0 of pair 2.
- Full plus simultaneous pop: FIFO full, final sell word handshaking and i_valid=1 in the same cycle -> new pair dropped (o_drop_count+1), count becomes DEPTH-1.
- Reset mid-packet: i_reset_n=0 during buy word 4 -> next cycle o_tvalid=0, o_drop_count=0, FIFO empty. A new pair afterwards streams from buy word 0.
